alu_mult_sequencer: RTL and testbench

Multi-cycle unsigned 32x32 multiplier controller that time-shares the processor's combinational 32-bit ALU using only its ADD operation (ALUOperation 4'b0011). On `start` it owns the ALU for 32 cycles, one shift-add iteration per cycle, and returns a 64-bit product split into hi/lo words. The top level uses `alu_own` to steer the ALU operand/opcode mux between the normal datapath and this block.

---
 rtl/alu_mult_sequencer.sv | 121 ++++++++++++
 tb/tb_alu_mult_sequencer.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/alu_mult_sequencer.sv
// Shift-add 32x32 unsigned multiplier that borrows the shared ALU's ADD for
// one iteration per cycle, then presents a 64-bit product as hi/lo words.
module alu_mult_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] multiplicand,
    input  logic [WIDTH-1:0] multiplier,
    input  logic [WIDTH-1:0] alu_result,
    output logic             alu_own,
    output logic [3:0]       alu_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product_hi,
    output logic [WIDTH-1:0] product_lo,
    output logic [1:0]       dbg_state
);

    // Handshake: start is a request sampled only in IDLE or DONE (no ready
    // signal; it is simply ignored while BUSY). done is a one-cycle pulse
    // marking a valid product; there is no backpressure on the result.

    localparam logic [3:0] ALU_ADD = 4'b0011;
    localparam logic [3:0] ALU_NOP = 4'b0000;
    localparam logic [5:0] LAST_ITER = 6'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [5:0]       cnt_q, cnt_d;
    logic             carry;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            hi_q    <= '0;
            lo_q    <= '0;
            mcand_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            mcand_q <= mcand_d;
            cnt_q   <= cnt_d;
        end
    end

    // The ALU has no carry-out, so the carry is recovered from wrap-around.
    assign carry = (alu_result < hi_q);

    always_comb begin
        state_d = state_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        mcand_d = mcand_q;
        cnt_d   = cnt_q;
        alu_own = 1'b0;
        alu_op  = ALU_NOP;
        alu_a   = '0;
        alu_b   = '0;
        busy    = 1'b0;
        done    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mcand_d = multiplicand;
                    lo_d    = multiplier;
                    hi_d    = '0;
                    cnt_d   = '0;
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                busy    = 1'b1;
                alu_own = 1'b1;
                alu_op  = ALU_ADD;
                alu_a   = hi_q;
                alu_b   = lo_q[0] ? mcand_q : '0;
                hi_d    = {carry, alu_result[WIDTH-1:1]};
                lo_d    = {alu_result[0], lo_q[WIDTH-1:1]};
                cnt_d   = cnt_q + 6'd1;
                if (cnt_q == LAST_ITER) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done = 1'b1;
                if (start) begin
                    mcand_d = multiplicand;
                    lo_d    = multiplier;
                    hi_d    = '0;
                    cnt_d   = '0;
                    state_d = S_BUSY;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign product_hi = hi_q;
    assign product_lo = lo_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_alu_mult_sequencer.sv
// Randomized and directed bench for alu_mult_sequencer; the shared ALU is
// modelled here and products are predicted with a native 64-bit multiply.
module tb_alu_mult_sequencer;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] multiplicand;
    logic [31:0] multiplier;
    logic [31:0] alu_result;
    logic        alu_own;
    logic [3:0]  alu_op;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic        busy;
    logic        done;
    logic [31:0] product_hi;
    logic [31:0] product_lo;
    logic [1:0]  dbg_state;

    int n_checks = 0;
    int n_errs   = 0;
    logic [63:0] exp_q[$];

    alu_mult_sequencer #(.WIDTH(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .alu_result   (alu_result),
        .alu_own      (alu_own),
        .alu_op       (alu_op),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .busy         (busy),
        .done         (done),
        .product_hi   (product_hi),
        .product_lo   (product_lo),
        .dbg_state    (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // shared ALU: only ADD matters; any other opcode yields junk
    assign alu_result = (alu_op == 4'b0011) ? (alu_a + alu_b) : 32'hDEAD_BEEF;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic idle_step();
        start = 1'b0;
        @(negedge clk);
    endtask

    // Called at a negedge with the DUT in IDLE or DONE; returns at the DONE sample.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input bit hold,
                          input int poke_at, input bit zero_b);
        logic [63:0] exp;
        start        = 1'b1;
        multiplicand = a;
        multiplier   = b;
        exp_q.push_back(64'(a) * 64'(b));
        @(posedge clk);
        @(negedge clk);
        if (!hold) start = 1'b0;
        for (int k = 1; k <= 32; k++) begin
            chk("busy_own", {63'b0, alu_own}, 64'd1);
            chk("busy_op", {60'b0, alu_op}, 64'h3);
            chk("busy_nodone", {63'b0, done}, 64'd0);
            if (zero_b) chk("zero_mcand_alu_b", {32'b0, alu_b}, 64'd0);
            if (k == poke_at) begin
                start        = 1'b1;
                multiplicand = ~a;
                multiplier   = b + 32'd1;
            end
            if (k == poke_at + 1) start = 1'b0;
            @(negedge clk);
        end
        chk("done_pulse", {63'b0, done}, 64'd1);
        chk("done_busy_low", {63'b0, busy}, 64'd0);
        chk("done_own_low", {63'b0, alu_own}, 64'd0);
        chk("done_op_nop", {60'b0, alu_op}, 64'h0);
        exp = exp_q.pop_front();
        chk("product", {product_hi, product_lo}, exp);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_busy"}, {63'b0, busy}, 64'd0);
        chk({tag, "_done"}, {63'b0, done}, 64'd0);
        chk({tag, "_own"}, {63'b0, alu_own}, 64'd0);
        chk({tag, "_op"}, {60'b0, alu_op}, 64'd0);
        chk({tag, "_a"}, {32'b0, alu_a}, 64'd0);
        chk({tag, "_b"}, {32'b0, alu_b}, 64'd0);
        chk({tag, "_prod"}, {product_hi, product_lo}, 64'd0);
        chk({tag, "_state"}, {62'b0, dbg_state}, 64'd0);
    endtask

    initial begin
        logic [31:0] ra, rb;
        reset        = 1'b0;
        start        = 1'b0;
        multiplicand = '0;
        multiplier   = '0;
        #1;
        check_all_zero("reset");
        @(negedge clk);
        reset = 1'b1;

        // 3 x 5, then hold in IDLE for 10 cycles
        run_op(32'd3, 32'd5, 1'b0, 0, 1'b0);
        start = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("idle_hold_prod", {product_hi, product_lo}, 64'h0000_0000_0000_000F);
            chk("idle_hold_done", {63'b0, done}, 64'd0);
        end

        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0, 1'b0);
        chk("max_hi", {32'b0, product_hi}, 64'hFFFF_FFFE);
        chk("max_lo", {32'b0, product_lo}, 64'h0000_0001);
        idle_step();
        run_op(32'h0, 32'h1234_5678, 1'b0, 0, 1'b1);
        idle_step();
        run_op(32'h8000_0000, 32'h2, 1'b0, 0, 1'b0);
        chk("pow2_hi", {32'b0, product_hi}, 64'h1);
        idle_step();

        // start pulsed mid-operation must be ignored
        run_op(32'h0001_2345, 32'h0006_789A, 1'b0, 10, 1'b0);
        idle_step();

        // asynchronous reset during iteration 10
        start        = 1'b1;
        multiplicand = 32'hAAAA_5555;
        multiplier   = 32'h1357_9BDF;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        chk("pre_abort_busy", {63'b0, busy}, 64'd1);
        reset = 1'b0;
        #1;
        check_all_zero("abort");
        @(negedge clk);
        reset = 1'b1;
        run_op(32'd7, 32'd6, 1'b0, 0, 1'b0);
        chk("after_abort", {product_hi, product_lo}, 64'h2A);
        idle_step();

        // back-to-back with start held high
        run_op(32'd2, 32'd9, 1'b1, 0, 1'b0);
        chk("b2b_first", {product_hi, product_lo}, 64'h12);
        run_op(32'd4, 32'd4, 1'b0, 0, 1'b0);
        chk("b2b_second", {product_hi, product_lo}, 64'h10);
        idle_step();
        chk("back_to_idle", {62'b0, dbg_state}, 64'd0);

        // randomized operands
        for (int i = 0; i < 12; i++) begin
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 3))
                0: ra = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
                1: rb = 32'($urandom_range(0, 7));
                default: ;
            endcase
            run_op(ra, rb, 1'b0, (i % 3 == 0) ? int'($urandom_range(1, 31)) : 0, 1'b0);
            if ($urandom_range(0, 1) == 1) idle_step();
        end
        idle_step();

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
